// File: rtl/sha256_msg_padder.sv
// Streams a FIPS 180-4 padded message to the SHA-256 core: raw words fetched from
// a 1-cycle-latency read-only memory, then the 0x80 marker, zero fill and bit length.
module sha256_msg_padder #(
    parameter int unsigned NUM_OF_WORDS = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] input_addr,
    output logic        busy,
    output logic        done,
    output logic        memory_clk,
    output logic [15:0] memory_addr,
    input  logic [31:0] memory_read_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_block_last,
    output logic        out_msg_last
);

    localparam int unsigned NUM_BLOCKS  = (NUM_OF_WORDS + 2) / 16 + 1;
    localparam int unsigned TOTAL_WORDS = 16 * NUM_BLOCKS;
    localparam int unsigned IDX_W       = $clog2(TOTAL_WORDS);

    localparam logic [IDX_W-1:0] MSG_WORDS  = IDX_W'(NUM_OF_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(TOTAL_WORDS - 1);
    localparam logic [31:0]      BIT_LEN_LO = 32'(NUM_OF_WORDS * 32);
    localparam logic [31:0]      PAD_MARK   = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_OUT,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      base_q, base_d;
    logic [31:0]      out_word_q, out_word_d;
    logic [15:0]      memory_addr_q, memory_addr_d;

    logic [IDX_W-1:0] idx_next;
    logic [15:0]      next_addr;
    logic [31:0]      pad_word;

    assign idx_next  = idx_q + 1'b1;
    assign next_addr = base_q + 16'(idx_next);

    // Upper length word (T-2) is always zero because N*32 fits in 32 bits.
    always_comb begin
        pad_word = '0;
        if (idx_q == MSG_WORDS) begin
            pad_word = PAD_MARK;
        end else if (idx_q == LAST_IDX) begin
            pad_word = BIT_LEN_LO;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            base_q        <= '0;
            out_word_q    <= '0;
            memory_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            base_q        <= base_d;
            out_word_q    <= out_word_d;
            memory_addr_q <= memory_addr_d;
        end
    end

    // The read address is loaded on the transition into ISSUE so it is already
    // registered and stable for the whole ISSUE cycle; it holds everywhere else.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        base_d        = base_q;
        out_word_d    = out_word_q;
        memory_addr_d = memory_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d        = input_addr;
                    idx_d         = '0;
                    memory_addr_d = input_addr;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (idx_q < MSG_WORDS) begin
                    state_d = ST_CAPTURE;
                end else begin
                    out_word_d = pad_word;
                    state_d    = ST_OUT;
                end
            end
            ST_CAPTURE: begin
                out_word_d = memory_read_data;
                state_d    = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_next;
                        state_d = ST_ISSUE;
                        if (idx_next < MSG_WORDS) begin
                            memory_addr_d = next_addr;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign out_valid      = (state_q == ST_OUT);
    assign out_block_last = out_valid && (idx_q[3:0] == 4'hF);
    assign out_msg_last   = out_valid && (idx_q == LAST_IDX);
    assign out_word       = out_word_q;
    assign memory_addr    = memory_addr_q;
    assign memory_clk     = clk;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench: three padders (N=40, 13, 14) share clock and reset; each has a
// synchronous memory model returning mem[a] = a - 100.
module tb_sha256_msg_padder;

    localparam int NINST = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start   [NINST];
    logic [15:0] addr_in [NINST];
    logic        ready   [NINST];
    logic        busy    [NINST];
    logic        done    [NINST];
    logic        valid   [NINST];
    logic        blast   [NINST];
    logic        mlast   [NINST];
    logic [15:0] maddr   [NINST];
    logic [31:0] word    [NINST];

    logic [33:0] cap [NINST][1024];
    int cap_n    [NINST] = '{0, 0, 0};
    int done_cnt [NINST] = '{0, 0, 0};
    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < NINST; g++) begin : g_dut
        logic        mclk;
        logic [31:0] rdata;
        sha256_msg_padder #(.NUM_OF_WORDS(g == 0 ? 40 : (g == 1 ? 13 : 14))) u_dut (
            .clk              (clk),
            .rst_n            (rst_n),
            .start            (start[g]),
            .input_addr       (addr_in[g]),
            .busy             (busy[g]),
            .done             (done[g]),
            .memory_clk       (mclk),
            .memory_addr      (maddr[g]),
            .memory_read_data (rdata),
            .out_valid        (valid[g]),
            .out_ready        (ready[g]),
            .out_word         (word[g]),
            .out_block_last   (blast[g]),
            .out_msg_last     (mlast[g])
        );
        always @(posedge mclk) rdata <= 32'(maddr[g]) - 32'd100;
    end

    // Records every accepted word as {block_last, msg_last, word}.
    always @(negedge clk) begin
        for (int g = 0; g < NINST; g++) begin
            if (valid[g] === 1'b1 && ready[g] === 1'b1) begin
                cap[g][cap_n[g] % 1024] = {blast[g], mlast[g], word[g]};
                cap_n[g] = cap_n[g] + 1;
            end
            if (done[g] === 1'b1) done_cnt[g] = done_cnt[g] + 1;
        end
    end

    function automatic int unsigned total_words(input int unsigned n);
        return 16 * ((n + 2) / 16 + 1);
    endfunction

    function automatic logic [33:0] exp_beat(input int unsigned n, input int unsigned base,
                                             input int unsigned i);
        int unsigned t;
        logic [31:0] w;
        t = total_words(n);
        if (i < n)           w = base + i - 100;
        else if (i == n)     w = 32'h8000_0000;
        else if (i == t - 1) w = n * 32;
        else                 w = 32'h0;
        return {(i % 16) == 15, i == t - 1, w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int g, input logic [15:0] a);
        start[g]   = 1'b1;
        addr_in[g] = a;
        tick();
        start[g]   = 1'b0;
    endtask

    task automatic wait_done(input int g, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            if (done[g] === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_words(input int g, input int b0, input int k, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            if (cap_n[g] - b0 >= k) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int g = 0; g < NINST; g++) begin
            start[g] = 1'b0; addr_in[g] = 16'h0; ready[g] = 1'b0;
        end
        #3;
        for (int g = 0; g < NINST; g++) begin
            n_cmp++; if (busy[g] !== 1'b0)  begin n_bad++; $display("FAIL rst_busy[%0d] got %b want 0", g, busy[g]); end
            n_cmp++; if (done[g] !== 1'b0)  begin n_bad++; $display("FAIL rst_done[%0d] got %b want 0", g, done[g]); end
            n_cmp++; if (valid[g] !== 1'b0) begin n_bad++; $display("FAIL rst_valid[%0d] got %b want 0", g, valid[g]); end
            n_cmp++; if (blast[g] !== 1'b0) begin n_bad++; $display("FAIL rst_blast[%0d] got %b want 0", g, blast[g]); end
            n_cmp++; if (mlast[g] !== 1'b0) begin n_bad++; $display("FAIL rst_mlast[%0d] got %b want 0", g, mlast[g]); end
            n_cmp++; if (word[g] !== 32'h0) begin n_bad++; $display("FAIL rst_word[%0d] got %h want 0", g, word[g]); end
            n_cmp++; if (maddr[g] !== 16'h0) begin n_bad++; $display("FAIL rst_maddr[%0d] got %h want 0", g, maddr[g]); end
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream_n40();
        int b0, d0;
        bit ok;
        logic [33:0] want;
        b0 = cap_n[0]; d0 = done_cnt[0];
        ready[0] = 1'b1;
        pulse_start(0, 16'd100);
        @(negedge clk);
        n_cmp++; if (busy[0] !== 1'b1)   begin n_bad++; $display("FAIL t1_busy_issue got %b want 1", busy[0]); end
        n_cmp++; if (valid[0] !== 1'b0)  begin n_bad++; $display("FAIL t1_valid_issue got %b want 0", valid[0]); end
        n_cmp++; if (maddr[0] !== 16'd100) begin n_bad++; $display("FAIL t1_maddr_issue got %0d want 100", maddr[0]); end
        @(negedge clk);
        n_cmp++; if (valid[0] !== 1'b0)  begin n_bad++; $display("FAIL t1_valid_capture got %b want 0", valid[0]); end
        @(negedge clk);
        n_cmp++; if (valid[0] !== 1'b1)  begin n_bad++; $display("FAIL t1_first_valid got %b want 1", valid[0]); end
        wait_done(0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL t1_done_timeout got 0 want 1"); end
        n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL t1_busy_in_done got %b want 1", busy[0]); end
        @(negedge clk);
        n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL t1_busy_after got %b want 0", busy[0]); end
        n_cmp++; if (done[0] !== 1'b0) begin n_bad++; $display("FAIL t1_done_width got %b want 0", done[0]); end
        n_cmp++; if (done_cnt[0] - d0 != 1) begin n_bad++; $display("FAIL t1_done_count got %0d want 1", done_cnt[0] - d0); end
        n_cmp++; if (cap_n[0] - b0 != 48) begin n_bad++; $display("FAIL t1_count got %0d want 48", cap_n[0] - b0); end
        for (int i = 0; i < 48; i++) begin
            want = exp_beat(40, 100, i);
            n_cmp++;
            if (cap[0][(b0 + i) % 1024] !== want) begin
                n_bad++; $display("FAIL t1_beat[%0d] got %h want %h", i, cap[0][(b0 + i) % 1024], want);
            end
        end
        n_cmp++; if (cap[0][(b0 + 47) % 1024] !== {2'b11, 32'h0000_0500}) begin
            n_bad++; $display("FAIL t1_len_word got %h want 300000500", cap[0][(b0 + 47) % 1024]);
        end
        tick();
    endtask

    task automatic test_exact_fit_n13();
        int b0;
        bit ok;
        logic [33:0] want;
        b0 = cap_n[1];
        ready[1] = 1'b1;
        pulse_start(1, 16'd100);
        wait_done(1, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL t2_done_timeout got 0 want 1"); end
        @(negedge clk);
        n_cmp++; if (cap_n[1] - b0 != 16) begin n_bad++; $display("FAIL t2_count got %0d want 16", cap_n[1] - b0); end
        for (int i = 0; i < 16; i++) begin
            want = exp_beat(13, 100, i);
            n_cmp++;
            if (cap[1][(b0 + i) % 1024] !== want) begin
                n_bad++; $display("FAIL t2_beat[%0d] got %h want %h", i, cap[1][(b0 + i) % 1024], want);
            end
        end
        n_cmp++; if (cap[1][(b0 + 13) % 1024] !== {2'b00, 32'h8000_0000}) begin
            n_bad++; $display("FAIL t2_pad_mark got %h want 080000000", cap[1][(b0 + 13) % 1024]);
        end
        n_cmp++; if (cap[1][(b0 + 15) % 1024] !== {2'b11, 32'h0000_01A0}) begin
            n_bad++; $display("FAIL t2_len_word got %h want 3000001a0", cap[1][(b0 + 15) % 1024]);
        end
        tick();
    endtask

    task automatic test_extra_block_n14();
        int b0;
        bit ok;
        logic [33:0] want;
        b0 = cap_n[2];
        ready[2] = 1'b1;
        pulse_start(2, 16'd100);
        wait_done(2, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL t3_done_timeout got 0 want 1"); end
        @(negedge clk);
        n_cmp++; if (cap_n[2] - b0 != 32) begin n_bad++; $display("FAIL t3_count got %0d want 32", cap_n[2] - b0); end
        for (int i = 0; i < 32; i++) begin
            want = exp_beat(14, 100, i);
            n_cmp++;
            if (cap[2][(b0 + i) % 1024] !== want) begin
                n_bad++; $display("FAIL t3_beat[%0d] got %h want %h", i, cap[2][(b0 + i) % 1024], want);
            end
        end
        n_cmp++; if (cap[2][(b0 + 15) % 1024] !== {2'b10, 32'h0}) begin
            n_bad++; $display("FAIL t3_w15 got %h want 200000000", cap[2][(b0 + 15) % 1024]);
        end
        n_cmp++; if (cap[2][(b0 + 31) % 1024] !== {2'b11, 32'h0000_01C0}) begin
            n_bad++; $display("FAIL t3_len_word got %h want 3000001c0", cap[2][(b0 + 31) % 1024]);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int b0, tgt;
        bit ok;
        logic [31:0] w_h;
        logic [15:0] a_h, a_want;
        logic [1:0]  f_h;
        logic [33:0] want;
        b0 = cap_n[0];
        ready[0] = 1'b1;
        pulse_start(0, 16'd100);
        for (int s = 0; s < 2; s++) begin
            tgt = (s == 0) ? 5 : 40;
            wait_words(0, b0, tgt, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL t4_reach[%0d] got 0 want 1", tgt); end
            ready[0] = 1'b0;
            ok = 1'b0;
            for (int c = 0; c < 10 && !ok; c++) begin
                @(negedge clk);
                if (valid[0] === 1'b1) ok = 1'b1;
            end
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL t4_valid_seen[%0d] got 0 want 1", tgt); end
            w_h = word[0]; a_h = maddr[0]; f_h = {blast[0], mlast[0]};
            want = exp_beat(40, 100, tgt);
            a_want = (tgt < 40) ? 16'(100 + tgt) : 16'd139;
            n_cmp++; if (w_h !== want[31:0]) begin n_bad++; $display("FAIL t4_word[%0d] got %h want %h", tgt, w_h, want[31:0]); end
            n_cmp++; if (a_h !== a_want) begin n_bad++; $display("FAIL t4_maddr[%0d] got %0d want %0d", tgt, a_h, a_want); end
            repeat (5) begin
                @(negedge clk);
                n_cmp++; if (valid[0] !== 1'b1) begin n_bad++; $display("FAIL t4_hold_valid[%0d] got %b want 1", tgt, valid[0]); end
                n_cmp++; if (word[0] !== w_h) begin n_bad++; $display("FAIL t4_hold_word[%0d] got %h want %h", tgt, word[0], w_h); end
                n_cmp++; if (maddr[0] !== a_h) begin n_bad++; $display("FAIL t4_hold_maddr[%0d] got %0d want %0d", tgt, maddr[0], a_h); end
                n_cmp++; if ({blast[0], mlast[0]} !== f_h) begin n_bad++; $display("FAIL t4_hold_flags[%0d] got %b want %b", tgt, {blast[0], mlast[0]}, f_h); end
            end
            tick();
            ready[0] = 1'b1;
        end
        wait_done(0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL t4_done_timeout got 0 want 1"); end
        @(negedge clk);
        n_cmp++; if (cap_n[0] - b0 != 48) begin n_bad++; $display("FAIL t4_count got %0d want 48", cap_n[0] - b0); end
        for (int i = 0; i < 48; i++) begin
            want = exp_beat(40, 100, i);
            n_cmp++;
            if (cap[0][(b0 + i) % 1024] !== want) begin
                n_bad++; $display("FAIL t4_beat[%0d] got %h want %h", i, cap[0][(b0 + i) % 1024], want);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_stream();
        int b0;
        bit ok;
        logic [33:0] want;
        b0 = cap_n[0];
        ready[0] = 1'b1;
        pulse_start(0, 16'd100);
        wait_words(0, b0, 20, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL t5_reach got 0 want 1"); end
        ready[0] = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(negedge clk);
            if (valid[0] === 1'b1) ok = 1'b1;
        end
        n_cmp++; if (word[0] !== 32'd20) begin n_bad++; $display("FAIL t5_w20 got %h want 00000014", word[0]); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (valid[0] !== 1'b0) begin n_bad++; $display("FAIL t5_valid_rst got %b want 0", valid[0]); end
        n_cmp++; if (busy[0] !== 1'b0)  begin n_bad++; $display("FAIL t5_busy_rst got %b want 0", busy[0]); end
        n_cmp++; if (word[0] !== 32'h0) begin n_bad++; $display("FAIL t5_word_rst got %h want 0", word[0]); end
        n_cmp++; if (maddr[0] !== 16'h0) begin n_bad++; $display("FAIL t5_maddr_rst got %h want 0", maddr[0]); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        ready[0] = 1'b1;
        b0 = cap_n[0];
        pulse_start(0, 16'd300);
        wait_done(0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL t5_done_timeout got 0 want 1"); end
        @(negedge clk);
        n_cmp++; if (cap_n[0] - b0 != 48) begin n_bad++; $display("FAIL t5_count got %0d want 48", cap_n[0] - b0); end
        for (int i = 0; i < 48; i++) begin
            want = exp_beat(40, 300, i);
            n_cmp++;
            if (cap[0][(b0 + i) % 1024] !== want) begin
                n_bad++; $display("FAIL t5_beat[%0d] got %h want %h", i, cap[0][(b0 + i) % 1024], want);
            end
        end
        tick();
    endtask

    task automatic test_start_ignored();
        int b0;
        bit ok;
        logic [33:0] want;
        b0 = cap_n[0];
        ready[0] = 1'b1;
        pulse_start(0, 16'd100);
        wait_words(0, b0, 10, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL t6_reach got 0 want 1"); end
        pulse_start(0, 16'd500);
        wait_done(0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL t6_done_timeout got 0 want 1"); end
        n_cmp++; if (cap_n[0] - b0 != 48) begin n_bad++; $display("FAIL t6_count got %0d want 48", cap_n[0] - b0); end
        for (int i = 0; i < 48; i++) begin
            want = exp_beat(40, 100, i);
            n_cmp++;
            if (cap[0][(b0 + i) % 1024] !== want) begin
                n_bad++; $display("FAIL t6_beat[%0d] got %h want %h", i, cap[0][(b0 + i) % 1024], want);
            end
        end
        // start raised inside the done cycle, kept high into the following IDLE cycle
        #1 start[0] = 1'b1; addr_in[0] = 16'd500;
        tick();
        addr_in[0] = 16'd700;
        @(negedge clk);
        n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL t6_done_start got busy %b want 0", busy[0]); end
        n_cmp++; if (maddr[0] !== 16'd139) begin n_bad++; $display("FAIL t6_maddr_hold got %0d want 139", maddr[0]); end
        tick();
        start[0] = 1'b0;
        b0 = cap_n[0];
        @(negedge clk);
        n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL t6_restart got busy %b want 1", busy[0]); end
        n_cmp++; if (maddr[0] !== 16'd700) begin n_bad++; $display("FAIL t6_restart_addr got %0d want 700", maddr[0]); end
        wait_done(0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL t6_done2_timeout got 0 want 1"); end
        @(negedge clk);
        n_cmp++; if (cap_n[0] - b0 != 48) begin n_bad++; $display("FAIL t6_count2 got %0d want 48", cap_n[0] - b0); end
        for (int i = 0; i < 48; i++) begin
            want = exp_beat(40, 700, i);
            n_cmp++;
            if (cap[0][(b0 + i) % 1024] !== want) begin
                n_bad++; $display("FAIL t6_beat2[%0d] got %h want %h", i, cap[0][(b0 + i) % 1024], want);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_stream_n40();
        test_exact_fit_n13();
        test_extra_block_n14();
        test_backpressure();
        test_reset_mid_stream();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
